// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset CPU.
// Holds the fetch-stage reset defaults, the opcode and funct values that the
// front end cares about, and the redirect selector that passes from
// next_pc_gen to fetch_unit.
package cpu_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [DATA_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

    // Opcode / funct encodings that cause a change of control flow
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    // Which kind of redirect, if any, the ID-stage instruction requests
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_JR   = 2'd1,
        RD_J    = 2'd2,
        RD_BR   = 2'd3
    } redirect_e;

endpackage

// File: rtl/next_pc_gen.sv
// Redirect target computation for the fetch stage (purely combinational).
// Ports:
//   id_valid     - IF/ID slot holds a real instruction; gates all decoder inputs
//   stall        - hazard hold; no redirect is selected while asserted
//   Branch/Jump/JR/Zero - decoder and ALU controls for the ID-stage instruction
//   Imm16        - branch immediate (word offset, signed)
//   TargetInstr  - 26-bit jump target field
//   JRAddr       - Rs value for JR
//   id_pcplus4   - PC+4 of the ID-stage instruction
//   sel          - chosen redirect kind (RD_NONE when the PC advances normally)
//   target       - new PC when sel != RD_NONE
//   jr_misalign  - a JR is being taken to an address with nonzero low bits
module next_pc_gen
    import cpu_pkg::*;
(
    input  logic              id_valid,
    input  logic              stall,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              JR,
    input  logic              Zero,
    input  logic [15:0]       Imm16,
    input  logic [25:0]       TargetInstr,
    input  logic [31:0]       JRAddr,
    input  logic [31:0]       id_pcplus4,
    output redirect_e         sel,
    output logic [31:0]       target,
    output logic              jr_misalign
);

    // Sign-extended immediate scaled to a byte offset
    function automatic logic signed [31:0] br_offset(input logic signed [15:0] imm);
        logic signed [31:0] ext;
        ext = {{16{imm[15]}}, imm};
        return ext <<< 2;
    endfunction

    logic [31:0] jr_target;
    logic [31:0] j_target;
    logic [31:0] br_target;

    assign jr_target = {JRAddr[31:2], 2'b00};
    assign j_target  = {id_pcplus4[31:28], TargetInstr, 2'b00};
    assign br_target = id_pcplus4 + 32'(br_offset(Imm16));

    // Nested ifs keep JR out of the picture when Jump=0 and Branch out of
    // the picture when Jump=1, so undriven decoder fields cannot leak in.
    always_comb begin
        sel    = RD_NONE;
        target = br_target;
        if (id_valid && !stall) begin
            if (Jump) begin
                if (JR) begin
                    sel    = RD_JR;
                    target = jr_target;
                end else begin
                    sel    = RD_J;
                    target = j_target;
                end
            end else if (Branch && !Zero) begin
                sel    = RD_BR;
                target = br_target;
            end
        end
    end

    assign jr_misalign = (sel == RD_JR) && (JRAddr[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline register.
// Holds the PC, addresses instruction memory and registers the fetched word
// plus its PC+4 for decode. A taken redirect loads the target into the PC
// and squashes the word fetched in the same cycle (one bubble, no delay slot).
// Ports:
//   clk, reset   - clock; synchronous active-high reset
//   Stall        - freeze PC and IF/ID, defer any redirect
//   Branch, Jump, JR, Zero, Imm16, TargetInstr, JRAddr - redirect inputs
//   IMemData     - instruction word at IMemAddr (combinational memory)
//   IMemAddr     - current PC
//   IDInstr, IDPCPlus4, IDValid - IF/ID register contents
//   MisalignErr  - sticky flag: a JR target had nonzero low bits
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JR,
    input  logic        Zero,
    input  logic [15:0] Imm16,
    input  logic [25:0] TargetInstr,
    input  logic [31:0] JRAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] IMemAddr,
    output logic [31:0] IDInstr,
    output logic [31:0] IDPCPlus4,
    output logic        IDValid,
    output logic        MisalignErr
);

    logic [31:0] pc_p0;
    logic [31:0] instr_p1;
    logic [31:0] pcplus4_p1;
    logic        vld_p1;
    logic        misalign_q;

    logic [31:0] pc_plus4_p0;
    redirect_e   sel;
    logic [31:0] target;
    logic        jr_misalign;

    assign pc_plus4_p0 = pc_p0 + 32'd4;

    next_pc_gen u_next_pc_gen (
        .id_valid    (vld_p1),
        .stall       (Stall),
        .Branch      (Branch),
        .Jump        (Jump),
        .JR          (JR),
        .Zero        (Zero),
        .Imm16       (Imm16),
        .TargetInstr (TargetInstr),
        .JRAddr      (JRAddr),
        .id_pcplus4  (pcplus4_p1),
        .sel         (sel),
        .target      (target),
        .jr_misalign (jr_misalign)
    );

    // ---- IF stage (PC) -> IF/ID boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0      <= RESET_PC;
            instr_p1   <= NOP_WORD;
            pcplus4_p1 <= 32'd0;
            vld_p1     <= 1'b0;
            misalign_q <= 1'b0;
        end else if (!Stall) begin
            if (sel != RD_NONE) begin
                pc_p0      <= target;
                instr_p1   <= NOP_WORD;
                pcplus4_p1 <= 32'd0;
                vld_p1     <= 1'b0;
            end else begin
                pc_p0      <= pc_plus4_p0;
                instr_p1   <= IMemData;
                pcplus4_p1 <= pc_plus4_p0;
                vld_p1     <= 1'b1;
            end
            if (jr_misalign) begin
                misalign_q <= 1'b1;
            end
        end
    end

    assign IMemAddr    = pc_p0;
    assign IDInstr     = instr_p1;
    assign IDPCPlus4   = pcplus4_p1;
    assign IDValid     = vld_p1;
    assign MisalignErr = misalign_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage plus IF/ID pipeline register for the MIPS-subset CPU. It holds the PC, addresses instruction memory, and registers the fetched word and PC+4 for the decode stage, where the control decoder consumes them. It consumes the decoder's Branch/Jump/JR/Imm16/TargetInstr outputs, the ALU Zero flag and the Rs register value. From these it redirects the PC with a one-bubble squash and no delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
NOP_WORD, 32'h0000_0000, instruction word driven on IDInstr when the slot is invalid.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
Stall  in  1  hazard hold: freeze PC and IF/ID, ignore redirects
Branch  in  1  decoder Branch for the ID-stage instruction (BNE)
Jump  in  1  decoder Jump for the ID-stage instruction
JR  in  1  decoder JR; meaningful only when Jump=1
Zero  in  1  ALU zero flag for the ID-stage compare
Imm16  in  16  decoder immediate
TargetInstr  in  26  decoder jump target field
JRAddr  in  32  register-file value of Rs for JR
IMemData  in  32  instruction memory read data, combinational from IMemAddr
IMemAddr  out  32  current PC
IDInstr  out  32  IF/ID instruction word, feeds decoder Instr
IDPCPlus4  out  32  IF/ID PC+4 of IDInstr
IDValid  out  1  IF/ID slot holds a real instruction
MisalignErr  out  1  sticky: a JR target had nonzero bits [1:0]

Behaviour:
- Reset (overrides everything, including mid-stall or mid-redirect):
  - PC=RESET_PC, IDInstr=NOP_WORD, IDPCPlus4=0, IDValid=0, MisalignErr=0.
- Fetch latency: IMemData at PC in cycle n appears on IDInstr in cycle n+1; IDPCPlus4 = PC+4 in that cycle.
- Decoder inputs are qualified by IDValid. When IDValid=0 no redirect occurs, regardless of the values on Branch/Jump/JR (they may be X).
- Redirect decode, in priority order (evaluated only when IDValid=1 and Stall=0):
  1. Jump=1 and JR=1 -> target = {JRAddr[31:2],2'b00}. If JRAddr[1:0]!=0, set MisalignErr.
  2. Jump=1 and JR=0 -> target = {IDPCPlus4[31:28], TargetInstr, 2'b00}.
  3. Jump=0, Branch=1 and Zero=0 (BNE taken) -> target = IDPCPlus4 + (sign_extend(Imm16) << 2), modulo 2^32.
  4. Otherwise there is no redirect.
  - JR is not inspected when Jump=0. Branch is not inspected when Jump=1.
- Cycle update when Stall=0:
  - Redirect: PC<=target; IF/ID <= {NOP_WORD, 0, IDValid=0}. The word fetched this cycle is squashed, giving exactly one bubble.
  - No redirect: PC<=PC+4 (0xFFFF_FFFC wraps to 0); IDInstr<=IMemData; IDPCPlus4<=PC+4; IDValid<=1.
- Cycle update when Stall=1:
  - PC, IDInstr, IDPCPlus4 and IDValid all hold.
  - Redirects are not taken, because Zero and JRAddr are not yet valid. The redirect resolves on the first cycle with Stall=0.
- Back-to-back redirects cannot occur, because the squashed slot has IDValid=0.
- MisalignErr is cleared only by reset.
- PC[1:0] is always 00.

Decomposition:
- Shared package cpu_pkg:
  - NOP_WORD, RESET_PC defaults.
  - Opcode/funct constants (J, JR, BNE).
  - typedef redirect_e {RD_NONE, RD_JR, RD_J, RD_BR}.
- One sub-module, next_pc_gen: combinational target computation and redirect_e selection. fetch_unit keeps the PC and IF/ID registers.

Test Plan:
- Reset, then 3 cycles with IMemData=mem[PC] -> IMemAddr 0,4,8,12; IDInstr=mem[0] in cycle 1 with IDPCPlus4=4 and IDValid=1.
- BNE at 0x10 with Imm16=16'hFFFC and Zero=0 -> PC=0x14+(-16)=0x04 next cycle; following ID slot has IDValid=0 and IDInstr=0; then mem[0x04] appears.
- Same BNE with Zero=1 -> no redirect, PC continues 0x18, 0x1C.
- J with TargetInstr=26'h0000040 and IDPCPlus4=0x0000_0024 -> PC=0x0000_0100; one bubble. JR with JRAddr=0x0000_0203 -> PC=0x200 and MisalignErr=1, still 1 after 10 cycles.
- Stall=1 for 3 cycles while a J sits in ID -> PC/IDInstr unchanged; on the Stall=0 cycle the jump is taken.
- PC=0xFFFF_FFFC with no redirect -> PC=0x0000_0000. reset asserted during a stalled redirect -> PC=RESET_PC and IDValid=0 on the next edge.
